shift_register_fifo: RTL

//  Synchronous FIFO built on an inferred SRL16/SRL32 delay line: writes shift in at tap 0,

---
 rtl/shift_register_fifo.sv | 94 +++++++++
 1 files changed

// File: rtl/shift_register_fifo.sv
// rtl/shift_register_fifo.sv - SRL-style shift-register FIFO with a registered dynamic read tap
// Pushes shift in at tap 0; the oldest word is read from the tap tracked by r_rd_addr.
module shift_register_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         s_valid,
  output logic                         s_ready,
  input  logic [DATA_WIDTH-1:0]        s_data,
  output logic                         m_valid,
  input  logic                         m_ready,
  output logic [DATA_WIDTH-1:0]        m_data,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  generate
    if (DEPTH < 2) begin : g_bad_depth
      $error("shift_register_fifo: DEPTH must be at least 2");
    end
  endgenerate

  logic [DATA_WIDTH-1:0] r_sr [DEPTH];
  logic [CW-1:0]         r_count;
  logic [AW-1:0]         r_rd_addr;
  logic                  r_m_valid;
  logic                  r_s_ready;

  logic                  w_push;
  logic                  w_pop;
  logic [CW-1:0]         w_count_nxt;
  logic [AW-1:0]         w_rd_addr_nxt;

  assign w_push = s_valid & r_s_ready;
  assign w_pop  = r_m_valid & m_ready;

  // Storage has no reset so the shift column maps onto SRL primitives.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_sr[0] <= s_data;
      for (int i = 1; i < DEPTH; i++) begin
        r_sr[i] <= r_sr[i-1];
      end
    end
  end

  always_comb begin
    w_count_nxt   = r_count;
    w_rd_addr_nxt = r_rd_addr;
    case ({w_push, w_pop})
      2'b10: begin
        w_count_nxt = r_count + CW'(1);
        if (r_count != '0) begin
          w_rd_addr_nxt = r_rd_addr + AW'(1);
        end
      end
      2'b01: begin
        w_count_nxt = r_count - CW'(1);
        if (r_count != CW'(1)) begin
          w_rd_addr_nxt = r_rd_addr - AW'(1);
        end
      end
      default: begin
        w_count_nxt   = r_count;
        w_rd_addr_nxt = r_rd_addr;
      end
    endcase
  end

  // Flags are computed from the next occupancy so they stay registered.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_count   <= '0;
      r_rd_addr <= '0;
      r_m_valid <= 1'b0;
      r_s_ready <= 1'b0;
    end else begin
      r_count   <= w_count_nxt;
      r_rd_addr <= w_rd_addr_nxt;
      r_m_valid <= (w_count_nxt != '0);
      r_s_ready <= (w_count_nxt != CW'(DEPTH));
    end
  end

  assign m_data  = r_sr[r_rd_addr];
  assign m_valid = r_m_valid;
  assign s_ready = r_s_ready;
  assign count   = r_count;

endmodule
